// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// CSUM exists only when LOADER_CSUM_EN is defined.
package prog_loader_pkg;

    localparam logic [7:0]  HDR_BYTE         = 8'hA5;
    localparam int unsigned DEF_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
`ifdef LOADER_CSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } loaderState_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byteValid.
module prog_loader_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       frameErr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rxState_t         rxState, rxStateNext;
    logic [1:0]       syncFf;
    logic             rxPrev;
    logic             rxS;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       bitIdx, bitIdxNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             validNext;
    logic [7:0]       dataNext;
    logic             ferrNext;

    assign rxS = syncFf[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncFf    <= 2'b11;
            rxPrev    <= 1'b1;
            rxState   <= RX_IDLE;
            cnt       <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            byteValid <= 1'b0;
            byteData  <= '0;
            frameErr  <= 1'b0;
        end else begin
            syncFf    <= {syncFf[0], rx};
            rxPrev    <= rxS;
            rxState   <= rxStateNext;
            cnt       <= cntNext;
            bitIdx    <= bitIdxNext;
            shiftReg  <= shiftNext;
            byteValid <= validNext;
            byteData  <= dataNext;
            frameErr  <= ferrNext;
        end
    end

    // Start is a falling edge, confirmed low again at half a bit; otherwise a glitch.
    always_comb begin
        rxStateNext = rxState;
        cntNext     = cnt;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        validNext   = 1'b0;
        dataNext    = byteData;
        ferrNext    = frameErr;
        case (rxState)
            RX_IDLE: begin
                if (rxPrev && !rxS) begin
                    rxStateNext = RX_START;
                    cntNext     = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cntNext     = '0;
                    bitIdxNext  = '0;
                    rxStateNext = rxS ? RX_IDLE : RX_DATA;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cntNext    = '0;
                    shiftNext  = {rxS, shiftReg[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) begin
                        rxStateNext = RX_STOP;
                    end
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cntNext     = '0;
                    validNext   = 1'b1;
                    dataNext    = shiftReg;
                    ferrNext    = !rxS;
                    rxStateNext = RX_IDLE;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: UART frames -> instruction memory writes, holds the CPU in reset while loading.
// Define LOADER_CSUM_EN to require and check a trailing modulo-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        cpuRst,
    output logic        imemWE,
    output logic [15:0] imemAddr,
    output logic [15:0] imemData,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic       byteValid;
    logic [7:0] byteData;
    logic       frameErr;
    logic       isHdr;

    loaderState_t state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [CW-1:0] addrCnt, addrNext;
    logic [7:0]    hiReg, hiNext;
    logic          cpuRstNext, imemWENext, busyNext, doneNext, errNext;
    logic [15:0]   imemAddrNext, imemDataNext;
    logic          goErr, goDone;
`ifdef LOADER_CSUM_EN
    logic [7:0]    csumAcc, csumNext;
`endif

    prog_loader_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uartRx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .byteValid(byteValid),
        .byteData (byteData),
        .frameErr (frameErr)
    );

    assign isHdr = byteValid && !frameErr && (byteData == HDR_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            addrCnt  <= '0;
            hiReg    <= '0;
            cpuRst   <= 1'b0;
            imemWE   <= 1'b0;
            imemAddr <= '0;
            imemData <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef LOADER_CSUM_EN
            csumAcc  <= '0;
`endif
        end else begin
            state    <= stateNext;
            count    <= countNext;
            addrCnt  <= addrNext;
            hiReg    <= hiNext;
            cpuRst   <= cpuRstNext;
            imemWE   <= imemWENext;
            imemAddr <= imemAddrNext;
            imemData <= imemDataNext;
            busy     <= busyNext;
            done     <= doneNext;
            err      <= errNext;
`ifdef LOADER_CSUM_EN
            csumAcc  <= csumNext;
`endif
        end
    end

    // Frame FSM; done/err/cpuRst change on the transition so they appear one cycle after byteValid.
    always_comb begin
        stateNext    = state;
        countNext    = count;
        addrNext     = addrCnt;
        hiNext       = hiReg;
        cpuRstNext   = cpuRst;
        imemWENext   = 1'b0;
        imemAddrNext = imemAddr;
        imemDataNext = imemData;
        busyNext     = busy;
        doneNext     = done;
        errNext      = err;
        goErr        = 1'b0;
        goDone       = 1'b0;
`ifdef LOADER_CSUM_EN
        csumNext     = csumAcc;
`endif
        case (state)
            IDLE, ERR: begin
                if (isHdr) begin
                    stateNext  = COUNT;
                    doneNext   = 1'b0;
                    errNext    = 1'b0;
                    busyNext   = 1'b1;
                    cpuRstNext = 1'b1;
                    addrNext   = '0;
`ifdef LOADER_CSUM_EN
                    csumNext   = '0;
`endif
                end
            end
            COUNT: begin
                if (byteValid) begin
                    if (frameErr || byteData == 8'd0 || {1'b0, byteData} > 9'(DEPTH)) begin
                        goErr = 1'b1;
                    end else begin
                        countNext = CW'(byteData);
                        stateNext = HI;
                    end
                end
            end
            HI: begin
                if (byteValid) begin
                    if (frameErr) begin
                        goErr = 1'b1;
                    end else begin
                        hiNext    = byteData;
                        stateNext = LO;
`ifdef LOADER_CSUM_EN
                        csumNext  = csumAcc + byteData;
`endif
                    end
                end
            end
            LO: begin
                if (byteValid) begin
                    if (frameErr) begin
                        goErr = 1'b1;
                    end else begin
                        imemWENext   = 1'b1;
                        imemDataNext = {hiReg, byteData};
                        imemAddrNext = 16'(addrCnt[AW-1:0]);
                        addrNext     = addrCnt + CW'(1);
`ifdef LOADER_CSUM_EN
                        csumNext     = csumAcc + byteData;
`endif
                        if (addrNext == count) begin
`ifdef LOADER_CSUM_EN
                            stateNext = CSUM;
`else
                            goDone = 1'b1;
`endif
                        end else begin
                            stateNext = HI;
                        end
                    end
                end
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
                if (byteValid) begin
                    if (frameErr || byteData != csumAcc) begin
                        goErr = 1'b1;
                    end else begin
                        goDone = 1'b1;
                    end
                end
            end
`endif
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (goErr) begin
            stateNext = ERR;
            errNext   = 1'b1;
            busyNext  = 1'b0;
        end
        if (goDone) begin
            stateNext  = DONE;
            doneNext   = 1'b1;
            busyNext   = 1'b0;
            cpuRstNext = 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level model checked every cycle plus literal spot checks.
module tb_prog_loader;

    localparam int C     = 16;
    localparam int DEPTH = 128;
    // Edges from the start-bit drive to the registered loader outputs of that byte.
    localparam int UPD   = C / 2 + 4 + 9 * C;
`ifdef LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        cpuRst, imemWE, busy, done, err;
    logic [15:0] imemAddr, imemData;

    prog_loader #(
        .CLKS_PER_BIT(C),
        .DEPTH       (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .cpuRst  (cpuRst),
        .imemWE  (imemWE),
        .imemAddr(imemAddr),
        .imemData(imemData),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    logic        expCpu = 1'b0, expWE = 1'b0, expBusy = 1'b0, expDone = 1'b0, expErr = 1'b0;
    logic [15:0] expAddr = '0, expData = '0;
    bit          inFrame = 1'b0;
    logic [7:0]  fr[$];
    logic [7:0]  txq[$];
    logic [31:0] wrLog[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        inFrame = 1'b0;
        expCpu  = 1'b0;
        expWE   = 1'b0;
        expBusy = 1'b0;
        expDone = 1'b0;
        expErr  = 1'b0;
        expAddr = '0;
        expData = '0;
    endtask

    task automatic modelFail();
        inFrame = 1'b0;
        expErr  = 1'b1;
        expBusy = 1'b0;
    endtask

    task automatic modelAccept();
        inFrame = 1'b0;
        expDone = 1'b1;
        expBusy = 1'b0;
        expCpu  = 1'b0;
    endtask

    // Frame-level interpretation of one received byte.
    task automatic modelByte(input logic [7:0] b, input logic ferr);
        int n, pos, sum;
        if (!inFrame) begin
            if (!ferr && b == 8'hA5) begin
                inFrame = 1'b1;
                fr.delete();
                expBusy = 1'b1;
                expCpu  = 1'b1;
                expDone = 1'b0;
                expErr  = 1'b0;
            end
            return;
        end
        if (ferr) begin
            modelFail();
            return;
        end
        fr.push_back(b);
        n = int'(fr[0]);
        if (fr.size() == 1) begin
            if (n == 0 || n > DEPTH) modelFail();
            return;
        end
        pos = fr.size() - 1;
        if (pos <= 2 * n) begin
            if (pos % 2 == 0) begin
                expWE   = 1'b1;
                expAddr = 16'(pos / 2 - 1);
                expData = {fr[pos-1], b};
            end
            if (!CSUM_ON && pos == 2 * n) modelAccept();
        end else begin
            sum = 0;
            for (int k = 1; k <= 2 * n; k++) sum += int'(fr[k]);
            if (8'(sum) == b) modelAccept();
            else modelFail();
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < 10 * C; i++) begin
            @(posedge clk); #1;
            if (i == UPD) modelByte(b, !stopBit);
            rx = bits[i / C];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx = 1'b1;
        end
    endtask

    task automatic sendRange(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) sendByte(txq[i], 1'b1);
    endtask

    task automatic addCsum(input bit bad);
        int sum;
        sum = 0;
        for (int i = 2; i < txq.size(); i++) sum += int'(txq[i]);
        if (CSUM_ON) txq.push_back(bad ? 8'h00 : 8'(sum));
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Every-cycle comparison against the model; also logs DUT writes.
    always @(negedge clk) begin
        check("outputs", {27'd0, cpuRst, imemWE, busy, done, err, imemAddr, imemData},
              {27'd0, expCpu, expWE, expBusy, expDone, expErr, expAddr, expData});
        if (imemWE) wrLog.push_back({imemAddr, imemData});
        expWE = 1'b0;
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        modelReset();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("resetOut", {cpuRst, imemWE, busy, done, err, imemAddr, imemData}, '0);
        idle(20);

        // Basic two-word frame.
        wrLog.delete();
        txq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        addCsum(1'b0);
`ifdef LOADER_CSUM_EN
        check("csumValue", txq[6], 8'hBE);
`endif
        sendRange(0, txq.size() - 1);
        idle(20);
        check("f1Count", wrLog.size(), 2);
        check("f1Word0", wrLog[0], {16'd0, 16'h1234});
        check("f1Word1", wrLog[1], {16'd1, 16'hABCD});
        check("f1Flags", {done, err, cpuRst, busy}, 4'b1000);

`ifdef LOADER_CSUM_EN
        // Bad checksum: writes happen, then err with CPU held.
        wrLog.delete();
        txq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        addCsum(1'b1);
        sendRange(0, txq.size() - 1);
        idle(20);
        check("badCsCount", wrLog.size(), 2);
        check("badCsFlags", {done, err, cpuRst, busy}, 4'b0110);
        txq = '{8'hA5, 8'h01, 8'h13, 8'h57};
        addCsum(1'b0);
        sendRange(0, txq.size() - 1);
        idle(20);
        check("recoverFlags", {done, err, cpuRst, busy}, 4'b1000);
        check("recoverWord", wrLog[wrLog.size()-1], {16'd0, 16'h1357});
`endif

        // Count errors.
        wrLog.delete();
        txq = '{8'hA5, 8'h00};
        sendRange(0, 1);
        idle(20);
        check("cnt0Flags", {done, err, cpuRst, busy}, 4'b0110);
        txq = '{8'hA5, 8'h81};
        sendRange(0, 1);
        idle(20);
        check("cnt81Flags", {done, err, cpuRst, busy}, 4'b0110);
        check("cntErrWrites", wrLog.size(), 0);

        // Framing error in HI.
        txq = '{8'hA5, 8'h02};
        sendRange(0, 1);
        sendByte(8'h77, 1'b0);
        idle(2 * C);
        check("ferrFlags", {done, err, cpuRst, busy}, 4'b0110);
        check("ferrWrites", wrLog.size(), 0);

        // Short glitch on an idle line between bytes of a frame.
        wrLog.delete();
        txq = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        addCsum(1'b0);
        sendRange(0, 3);
        idle(20);
        repeat (C / 4) begin
            @(posedge clk); #1;
            rx = 1'b0;
        end
        idle(40);
        check("glitchMid", {done, err, cpuRst, busy}, 4'b0011);
        sendRange(4, txq.size() - 1);
        idle(20);
        check("glitchCount", wrLog.size(), 2);
        check("glitchFlags", {done, err, cpuRst, busy}, 4'b1000);

        // Reset mid-frame, stray byte ignored, fresh frame at address 0.
        wrLog.delete();
        txq = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        sendRange(0, 3);
        idle(20);
        check("preRstWord", wrLog[0], {16'd0, 16'h1122});
        doReset();
        @(negedge clk);
        check("midRstOut", {cpuRst, imemWE, busy, done, err, imemAddr, imemData}, '0);
        idle(30);
        sendByte(8'h55, 1'b1);
        idle(20);
        check("strayFlags", {done, err, cpuRst, busy}, 4'b0000);
        check("strayWrites", wrLog.size(), 1);
        txq = '{8'hA5, 8'h01, 8'hCA, 8'hFE};
        addCsum(1'b0);
        sendRange(0, txq.size() - 1);
        idle(20);
        check("freshWord", wrLog[wrLog.size()-1], {16'd0, 16'hCAFE});
        check("freshFlags", {done, err, cpuRst, busy}, 4'b1000);

        // Single-word frame.
        wrLog.delete();
        txq = '{8'hA5, 8'h01, 8'hBE, 8'hEF};
        addCsum(1'b0);
        sendRange(0, txq.size() - 1);
        idle(20);
        check("beefCount", wrLog.size(), 1);
        check("beefWord", wrLog[0], {16'd0, 16'hBEEF});
        check("beefFlags", {done, err, cpuRst, busy}, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
